// File: rtl/seq_1101_tx_pkg.sv
// Shared types and constants for the 1101-sync serial transmitter.
package seq_1101_tx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SYNC_LEN  = 4;
  localparam int unsigned GUARD_LEN = 2;
  localparam int unsigned HIST_W    = 3;
  localparam int unsigned CNT_W     = 4;

  localparam logic [SYNC_LEN-1:0] SYNC_PAT   = 4'b1101;
  localparam logic [HIST_W-1:0]   STUFF_HIST = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_t;

  // A data bit following 110 could complete a false 1101, so a 0 is forced instead.
  function automatic logic stuff_needed(input logic [HIST_W-1:0] hist);
    return hist == STUFF_HIST;
  endfunction

endpackage

// File: rtl/seq_1101_tx.sv
// Byte-to-serial transmitter: 1101 sync, MSB-first payload with 0-stuffing, two guard zeros.
module seq_1101_tx
  import seq_1101_tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    data_sent;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                dout_q, dout_d;
  logic                accept;
  logic                send_data;
  logic [1:0]          sync_idx;

  // Ready is decoded from registered state so it is valid in the first cycle out of reset.
  assign in_ready = !reset &&
                    ((state_q == IDLE) ||
                     ((state_q == GUARD) && (cnt_q == CNT_W'(GUARD_LEN - 1))));
  assign accept   = in_valid && in_ready;
  assign busy     = !reset && (state_q != IDLE);
  assign dout     = dout_q;

  // Next-state logic; dout_d is the bit that will be on the line in the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    dout_d    = 1'b0;
    send_data = 1'b0;
    sync_idx  = 2'd0;
    data_sent = (state_q == DATA) ? cnt_q : '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SYNC;
          cnt_d   = '0;
          shreg_d = in_data;
          dout_d  = SYNC_PAT[SYNC_LEN-1];
        end
      end

      SYNC: begin
        if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
          state_d   = DATA;
          send_data = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          sync_idx = 2'(SYNC_LEN - 2) - cnt_q[1:0];
          dout_d   = SYNC_PAT[sync_idx];
        end
      end

      DATA: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = GUARD;
          cnt_d   = '0;
        end else begin
          send_data = 1'b1;
        end
      end

      GUARD: begin
        if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
          cnt_d = '0;
          if (accept) begin
            state_d = SYNC;
            shreg_d = in_data;
            dout_d  = SYNC_PAT[SYNC_LEN-1];
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Either a stuff 0 (payload held) or the next payload bit.
    if (send_data) begin
      if (stuff_needed(hist_q)) begin
        dout_d = 1'b0;
        cnt_d  = data_sent;
      end else begin
        dout_d  = shreg_q[DATA_W-1];
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d   = data_sent + CNT_W'(1);
      end
    end

    hist_d = (state_d == IDLE) ? '0 : {hist_q[HIST_W-2:0], dout_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      hist_q  <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      hist_q  <= hist_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_seq_1101_tx.sv
// Directed and random checks of the seq_1101_tx frame format.
module tb_seq_1101_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned len;
    logic [15:0] bits;
  } vec_t;

  vec_t vecs[6];

  seq_1101_tx dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Offer one byte, then capture dout while busy (bounded).
  task automatic send_frame(input logic [7:0] d, input string name,
                            output logic [15:0] bits, output int unsigned len,
                            output int unsigned rdy_cnt);
    wait_ready(name);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    bits     = '0;
    len      = 0;
    rdy_cnt  = 0;
    while (busy === 1'b1 && len < 20) begin
      if (len < 16) bits[15-len] = dout;
      if (in_ready === 1'b1) rdy_cnt++;
      len++;
      tick();
    end
  endtask

  initial begin
    logic [15:0] bits;
    int unsigned len;
    int unsigned rdy_cnt;
    logic [27:0] b2b_act, b2b_rdy, b2b_exp, rdy_exp;
    int          acc_cnt, det_cnt, bad_pos, cyc;
    int unsigned pos;
    logic [3:0]  det;
    logic        acc;

    vecs[0] = '{data: 8'hFF, len: 14, bits: 16'hDFF0};
    vecs[1] = '{data: 8'hA5, len: 15, bits: 16'hD928};
    vecs[2] = '{data: 8'hB6, len: 16, bits: 16'hD998};
    vecs[3] = '{data: 8'h0F, len: 14, bits: 16'hD0F0};
    vecs[4] = '{data: 8'h6C, len: 16, bits: 16'hD660};
    vecs[5] = '{data: 8'hD0, len: 15, bits: 16'hDC80};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, $sformatf("vec%0d", i), bits, len, rdy_cnt);
      check($sformatf("vec%0d_bits", i), 32'(bits), 32'(vecs[i].bits));
      check($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].len));
      check($sformatf("vec%0d_ready_pulses", i), 32'(rdy_cnt), 32'd1);
      check($sformatf("vec%0d_idle_dout", i), 32'(dout), 32'd0);
      check($sformatf("vec%0d_idle_ready", i), 32'(in_ready), 32'd1);
    end

    // Back-to-back FF then 00 with in_valid held high.
    b2b_exp = {14'b11011111111100, 14'b11010000000000};
    rdy_exp = 28'h0004001;
    wait_ready("b2b");
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h00;
    for (int i = 0; i < 28; i++) begin
      if (i == 14) in_valid = 1'b0;
      b2b_act[27-i] = dout;
      b2b_rdy[27-i] = in_ready;
      tick();
    end
    check("b2b_dout", 32'(b2b_act), 32'(b2b_exp));
    check("b2b_ready", 32'(b2b_rdy), 32'(rdy_exp));
    check("b2b_end_busy", 32'(busy), 32'd0);

    // Reset during the third data bit abandons the frame.
    wait_ready("abort");
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("abort_pre_dout", 32'(dout), 32'd1);
    check("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_release_ready", 32'(in_ready), 32'd1);
    send_frame(8'h0F, "after_abort", bits, len, rdy_cnt);
    check("after_abort_bits", 32'(bits), 32'hD0F0);
    check("after_abort_len", 32'(len), 32'd14);

    // Random bytes and gaps; a 1101 detector must fire only on the 4th sync bit.
    acc_cnt = 0;
    det_cnt = 0;
    bad_pos = 0;
    cyc     = 0;
    pos     = 99;
    det     = 4'b0000;
    while (!(acc_cnt >= 500 && busy === 1'b0) && cyc < 30000) begin
      in_data  = 8'($urandom);
      in_valid = (acc_cnt < 500) && ($urandom_range(0, 3) != 0);
      acc      = in_valid && (in_ready === 1'b1);
      tick();
      cyc++;
      if (acc) begin
        acc_cnt++;
        pos = 1;
      end else if (pos < 99) begin
        pos++;
      end
      det = {det[2:0], dout};
      if (det == 4'b1101) begin
        det_cnt++;
        if (pos != 4) bad_pos++;
      end
    end
    in_valid = 1'b0;
    check("rand_accepts", 32'(acc_cnt), 32'd500);
    check("rand_detects", 32'(det_cnt), 32'd500);
    check("rand_bad_pos", 32'(bad_pos), 32'd0);
    check("rand_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_1101_tx.md
SEQ_1101_TX -- requirements
Module: seq_1101_tx

Interface
REQ-001 SHALL have no parameters; payload width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  payload byte; sampled on acceptance.
REQ-005 in_valid  input  1  payload byte available.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 dout  output  1  serial line; registered; idles at 0.
REQ-008 busy  output  1  high while a frame is being sent, including guard bits.

Function
REQ-009 SHALL accept a byte on a clk edge where in_valid and in_ready are both 1; in_data is captured at that edge.
REQ-010 SHALL assert in_ready in IDLE and in the second GUARD cycle only; in_valid is ignored at all other times.
REQ-011 SHALL use the state machine IDLE -> SYNC -> DATA -> GUARD -> IDLE.
  - From GUARD, it goes to SYNC instead of IDLE when a byte is accepted in the second GUARD cycle.
REQ-012 SYNC SHALL drive 1,1,0,1 on four consecutive cycles; the first bit appears on dout in the cycle after acceptance.
REQ-013 DATA SHALL send in_data MSB first, one bit per cycle.
REQ-014 SHALL keep a 3-bit history of the last bits driven on dout, including SYNC bits.
  - History is cleared to 000 on reset and in IDLE.
REQ-015 Stuffing: in DATA, if history == 110 before a data bit is sent, dout SHALL be 0 for that cycle and the data bit is held for the next cycle.
  - Consequence: the pattern 1101 never appears outside SYNC.
REQ-016 SHALL insert no stuff bit after the last data bit; at most 2 stuff bits occur per frame.
REQ-017 GUARD SHALL drive 0 for exactly 2 cycles.
REQ-018 Frame length SHALL be 14 cycles plus the number of stuff bits, i.e. 14 to 16 cycles.
REQ-019 dout SHALL be 0 in IDLE.
REQ-020 busy SHALL be 1 in SYNC, DATA and GUARD, and 0 in IDLE.
REQ-021 Back-to-back frames: with in_valid held high, the next frame's first SYNC bit SHALL follow the second GUARD bit directly, with no idle cycle.
REQ-022 Changes to in_data after acceptance SHALL have no effect on the frame in progress.

Reset
REQ-023 While reset is 1, the block SHALL:
  - go to IDLE,
  - clear the bit counters and history,
  - abandon any frame in progress without guard bits,
  - drive dout=0, busy=0, in_ready=0.
REQ-024 The first cycle after reset deasserts SHALL show IDLE with in_ready=1.

Structure
REQ-025 A shared package SHALL hold:
  - the state enumeration,
  - SYNC_PAT = 4'b1101,
  - GUARD_LEN = 2,
  - DATA_W = 8.
REQ-026 The block SHALL be a single module with no sub-module; the history register and stuffing check are inline.

Verification
REQ-027 Reset, then in_data=8'hFF accepted:
  - dout = 1101 11111111 00 (14 cycles),
  - busy high for 14 cycles,
  - no stuff bits.
REQ-028 in_data=8'hA5:
  - dout = 1101 10 0 100101 00 (15 cycles),
  - one stuff 0 after the SYNC/data sequence 1,0,1,1,0 reaches history 110.
REQ-029 in_data=8'hB6:
  - dout = 1101 10 0 110 0 110 00 (16 cycles, 2 stuff bits),
  - no stuff after the final history 110.
REQ-030 in_valid held high, bytes 8'hFF then 8'h00:
  - the second frame's 1101 starts on the cycle after the second guard 0,
  - in_ready pulses only in IDLE and in the second GUARD cycle.
REQ-031 Reset asserted during the 3rd DATA bit:
  - next cycle dout=0 and busy=0,
  - after release, a new byte 8'h0F gives dout = 1101 00001111 00.
REQ-032 500 random bytes with random in_valid gaps; a 1101 sequence-detector model on dout SHALL fire exactly once per frame, on the 4th SYNC bit.
